// File: rtl/keccak_theta_stage.sv
// ---------------------------------------------------------------------------
// keccak_theta_stage
//
// Two-stage pipelined Keccak-f[1600] theta step with valid/ready handshakes
// on both sides. A 5-bit round tag travels with each state so the later iota
// stage can pick its round constant.
//
//   Stage 1 captures the incoming state together with its column parities C.
//   Stage 2 folds the column effect D (derived from C) into the state and
//   drives the registered outputs.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   in_valid   in   1     upstream state and tag are valid
//   in_ready   out  1     stage accepts in_state this cycle
//   in_state   in   1600  lane (x,y) at bits 320*y + 64*x + z
//   in_round   in   5     round index, passed through unchanged
//   out_valid  out  1     out_state / out_round are valid
//   out_ready  in   1     downstream accepts this cycle
//   out_state  out  1600  theta(in_state), same lane layout
//   out_round  out  5     round tag belonging to out_state
// ---------------------------------------------------------------------------
module keccak_theta_stage #(
  parameter int LANE_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [25*LANE_W-1:0]  in_state,
  input  logic [4:0]            in_round,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [25*LANE_W-1:0]  out_state,
  output logic [4:0]            out_round
);

  localparam int NX      = 5;
  localparam int NY      = 5;
  localparam int ROW_W   = NX * LANE_W;       // one y-row of lanes
  localparam int STATE_W = NY * ROW_W;        // 1600
  localparam int PAR_W   = NX * LANE_W;       // 320 column-parity bits

  // -------------------------------------------------------------------------
  // Theta helpers. Column bit (x,z) lives at index x*LANE_W + z.
  // -------------------------------------------------------------------------

  // C[x][z] = XOR over all five rows of A[x,y,z].
  function automatic logic [PAR_W-1:0] column_parity(input logic [STATE_W-1:0] a);
    logic [PAR_W-1:0] c;
    c = {PAR_W{1'b0}};
    for (int x = 0; x < NX; x++) begin
      for (int z = 0; z < LANE_W; z++) begin
        for (int y = 0; y < NY; y++) begin
          c[x*LANE_W + z] = c[x*LANE_W + z] ^ a[y*ROW_W + x*LANE_W + z];
        end
      end
    end
    return c;
  endfunction

  // D[x][z] = C[x-1][z] ^ C[x+1][z-1]; the z-1 term wraps to the lane top,
  // which is the one-bit lane rotation of the reference algorithm.
  function automatic logic [PAR_W-1:0] column_effect(input logic [PAR_W-1:0] c);
    logic [PAR_W-1:0] d;
    d = {PAR_W{1'b0}};
    for (int x = 0; x < NX; x++) begin
      for (int z = 0; z < LANE_W; z++) begin
        d[x*LANE_W + z] = c[((x + NX - 1) % NX)*LANE_W + z]
                        ^ c[((x + 1) % NX)*LANE_W + ((z + LANE_W - 1) % LANE_W)];
      end
    end
    return d;
  endfunction

  // A'[x,y,z] = A[x,y,z] ^ D[x][z]; D is shared by all five rows.
  function automatic logic [STATE_W-1:0] theta_apply(input logic [STATE_W-1:0] a,
                                                     input logic [PAR_W-1:0]   d);
    logic [STATE_W-1:0] r;
    r = {STATE_W{1'b0}};
    for (int y = 0; y < NY; y++) begin
      r[y*ROW_W +: ROW_W] = a[y*ROW_W +: ROW_W] ^ d;
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Pipeline state
  // -------------------------------------------------------------------------
  logic                s1_valid;
  logic [STATE_W-1:0]  s1_state;
  logic [PAR_W-1:0]    s1_c;
  logic [4:0]          s1_round;
  logic                s2_valid;

  logic                s1_adv;
  logic                s2_adv;
  logic                in_fire;
  logic [PAR_W-1:0]    in_c;
  logic [PAR_W-1:0]    s1_d;

  // Advance logic: each stage moves when it is empty or the stage after it
  // moves. in_ready is two gate levels from out_ready and ignores in_valid.
  always_comb begin
    s2_adv  = !s2_valid || out_ready;
    s1_adv  = !s1_valid || s2_adv;
    in_fire = in_valid && s1_adv;
  end

  // Datapath: parity of the incoming state and column effect of stage 1.
  always_comb begin
    in_c = column_parity(in_state);
    s1_d = column_effect(s1_c);
  end

  // Stage 1 registers: capture the state, its column parities and its tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_state <= {STATE_W{1'b0}};
      s1_c     <= {PAR_W{1'b0}};
      s1_round <= 5'd0;
    end else if (s1_adv) begin
      // An advancing stage with no upstream transfer becomes empty.
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_state <= in_state;
        s1_c     <= in_c;
        s1_round <= in_round;
      end else begin
        s1_state <= s1_state;
        s1_c     <= s1_c;
        s1_round <= s1_round;
      end
    end else begin
      s1_valid <= s1_valid;
      s1_state <= s1_state;
      s1_c     <= s1_c;
      s1_round <= s1_round;
    end
  end

  // Stage 2 registers: apply the column effect and hold the result until the
  // downstream stage takes it, so out_state is stable under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_state <= {STATE_W{1'b0}};
      out_round <= 5'd0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      // Data only moves when there is a real state behind it, so a bubble
      // leaves the last result visible rather than loading stale stage-1 data.
      if (s1_valid) begin
        out_state <= theta_apply(s1_state, s1_d);
        out_round <= s1_round;
      end else begin
        out_state <= out_state;
        out_round <= out_round;
      end
    end else begin
      s2_valid  <= s2_valid;
      out_state <= out_state;
      out_round <= out_round;
    end
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = s1_adv;
    out_valid = s2_valid;
  end

endmodule

// File: tb/tb_keccak_theta_stage.sv
module tb_keccak_theta_stage;

  localparam int SW = 1600;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_state;
  logic [4:0]    in_round;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_state;
  logic [4:0]    out_round;

  always #5 clk = ~clk;

  keccak_theta_stage #(.LANE_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_round  (in_round),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_round (out_round)
  );

  typedef struct {
    logic [SW-1:0] st;
    logic [4:0]    rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference theta in the usual software form: 64-bit lanes, column
  // parities, D[x] = C[x-1] ^ rotl1(C[x+1]).
  function automatic logic [SW-1:0] theta_model(input logic [SW-1:0] a);
    logic [63:0]   lane [5][5];
    logic [63:0]   c [5];
    logic [63:0]   d [5];
    logic [63:0]   t;
    logic [SW-1:0] r;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        lane[x][y] = a[320*y + 64*x +: 64];
    for (int x = 0; x < 5; x++)
      c[x] = lane[x][0] ^ lane[x][1] ^ lane[x][2] ^ lane[x][3] ^ lane[x][4];
    for (int x = 0; x < 5; x++) begin
      t    = c[(x + 1) % 5];
      d[x] = c[(x + 4) % 5] ^ ((t << 1) | (t >> 63));
    end
    r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[320*y + 64*x +: 64] = lane[x][y] ^ d[x];
    return r;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < SW/32; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic check_vec(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
    logic [SW-1:0] diff;
    int first;
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      diff  = act ^ req;
      first = 0;
      for (int i = SW - 1; i >= 0; i--) if (diff[i] !== 1'b0) first = i;
      first = (first / 64) * 64;
      $display("FAIL %s: actual[%0d+:64]=%h required=%h (%0d bits differ)",
               name, first, act[first +: 64], req[first +: 64], $countones(diff));
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard: every valid output cycle must show the oldest outstanding
  // expected result; it is retired only when downstream takes it.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_output: actual out_valid=1 required no pending state");
        end else begin
          check_vec("sb_state", out_state, exp_q[0].st);
          check_val("sb_round", 32'(out_round), 32'(exp_q[0].rd));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back('{theta_model(in_state), in_round});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One state through an empty pipeline with out_ready=1, checking latency.
  task automatic directed(input string name, input logic [SW-1:0] st,
                          input logic [4:0] rd, input logic [SW-1:0] req);
    in_valid = 1'b1;
    in_state = st;
    in_round = rd;
    @(negedge clk);
    check_val({name, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_val({name, "_valid_k"}, 32'(out_valid), 32'd0);
    tick();
    check_val({name, "_valid_k1"}, 32'(out_valid), 32'd1);
    check_vec({name, "_state"}, out_state, req);
    check_val({name, "_round"}, 32'(out_round), 32'(rd));
    tick();
  endtask

  logic [SW-1:0] ones_v, bit0_v, single_exp, sa, sb, sc;
  int idx_list [11] = '{0, 64, 384, 704, 1024, 1344, 257, 577, 897, 1217, 1537};
  int sent, cyc;
  logic acc;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_round  = 5'd0;
    out_ready = 1'b0;
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_vec("rst_out_state", out_state, '0);
    check_val("rst_out_round", 32'(out_round), 32'd0);

    // Pin the model with hand-derived results.
    ones_v = '1;
    bit0_v = '0;
    bit0_v[0] = 1'b1;
    single_exp = '0;
    foreach (idx_list[i]) single_exp[idx_list[i]] = 1'b1;
    check_vec("model_zero", theta_model('0), '0);
    check_vec("model_ones", theta_model(ones_v), ones_v);
    check_vec("model_bit0", theta_model(bit0_v), single_exp);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    directed("zero", '0, 5'd0, '0);
    directed("ones", ones_v, 5'd7, ones_v);
    directed("bit0", bit0_v, 5'd23, single_exp);
    sa = rand_state();
    directed("rand", sa, 5'd11, theta_model(sa));

    // Back-pressure: A and B fill the pipe, C waits.
    sa = rand_state(); sb = rand_state(); sc = rand_state();
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = sa; in_round = 5'd3;
    @(negedge clk);
    check_val("bp_ready_a", 32'(in_ready), 32'd1);
    tick();
    in_state = sb; in_round = 5'd4;
    @(negedge clk);
    check_val("bp_ready_b", 32'(in_ready), 32'd1);
    tick();
    in_state = sc; in_round = 5'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("bp_ready_full", 32'(in_ready), 32'd0);
      check_vec("bp_hold_a", out_state, theta_model(sa));
      check_val("bp_hold_round", 32'(out_round), 32'd3);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_out_a", 32'(out_valid), 32'd1);
    check_val("bp_ready_rel", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check_val("bp_out_b", 32'(out_valid), 32'd1);
    check_vec("bp_state_b", out_state, theta_model(sb));
    tick();
    @(negedge clk);
    check_val("bp_out_c", 32'(out_valid), 32'd1);
    check_val("bp_round_c", 32'(out_round), 32'd5);
    tick();
    @(negedge clk);
    check_val("bp_empty", 32'(out_valid), 32'd0);
    tick();

    // Random streaming with random back-pressure.
    sent = 0;
    cyc  = 0;
    while (sent < 100 && cyc < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_state = rand_state();
        in_round = 5'($urandom_range(0, 23));
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_val("stream_sent", 32'(sent), 32'd100);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check_val("stream_drained", 32'(exp_q.size()), 32'd0);

    // Full throughput with out_ready held high.
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_state = rand_state();
      in_round = 5'($urandom_range(0, 23));
      @(negedge clk);
      check_val("tput_ready", 32'(in_ready), 32'd1);
      if (i >= 2) check_val("tput_valid", 32'(out_valid), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check_val("tput_drained", 32'(exp_q.size()), 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = rand_state(); in_round = 5'd9;
    tick();
    in_state = rand_state(); in_round = 5'd10;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check_val("mid_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_ready", 32'(in_ready), 32'd1);
    check_vec("mid_rst_state", out_state, '0);
    exp_q.delete();
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    sa = rand_state();
    directed("post_rst", sa, 5'd17, theta_model(sa));
    repeat (3) tick();
    check_val("final_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keccak_theta_stage.md
# keccak_theta_stage

Registered, two-stage pipelined Keccak-f[1600] theta step for the SHA3-256 datapath. It sits directly upstream of the combinational rho stage and feeds it one 1600-bit state per accepted transfer. It uses valid/ready handshakes on both sides and carries a 5-bit round tag alongside the state so that the later iota stage can select its round constant.

## Interface
- LANE_W, 64, lane width in bits; only 64 is supported (1600-bit state).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream state and tag are valid.
- in_ready  output  1  stage can accept in_state this cycle.
- in_state  input  1600  Keccak state; lane (x,y) occupies bits 320*y + 64*x + z, z = 0..63.
- in_round  input  5  round index 0..23, passed through unchanged.
- out_valid  output  1  out_state and out_round are valid.
- out_ready  input  1  downstream (rho) accepts this cycle.
- out_state  output  1600  theta(in_state), same lane layout.
- out_round  output  5  round tag associated with out_state.

## Operation
- Column parity: C[x][z] = XOR over y=0..4 of A[x,y,z] (320 bits).
- Column effect: D[x][z] = C[(x-1) mod 5][z] XOR C[(x+1) mod 5][(z-1) mod 64].
- Result: A'[x,y,z] = A[x,y,z] XOR D[x][z]. All index arithmetic is modulo 5 (x) and modulo 64 (z); there is no arithmetic beyond XOR.
- Stage 1 (S1) registers: s1_valid, s1_state (1600), s1_c (320, C computed from in_state), s1_round.
- Stage 2 (S2) registers: s2_valid, out_state (= s1_state XOR D(s1_c)), out_round. out_valid = s2_valid.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - On an upstream transfer (in_valid && in_ready), S1 loads in_state, C(in_state) and in_round.
  - If s1_adv holds and no upstream transfer occurs, s1_valid goes to 0.
  - If s2_adv holds, S2 loads from S1 and s2_valid <= s1_valid.
- When a stage does not advance, its registers hold. Data registers may load don't-care values when the stage's valid is 0.
- in_ready depends combinationally on out_ready, through at most two gate levels. It does not depend on in_valid.
- Reset (asynchronous, any time, including mid-transfer):
  - s1_valid = s2_valid = 0.
  - out_state = 0, out_round = 0.
  - in_ready reads 1 once reset is asserted.
  - In-flight states are discarded. After rst_n deasserts, the first rising edge may accept data.
- Simultaneous events: with both stages full and out_ready=1, one state leaves S2, S1 moves into S2, and a new state enters S1 in the same cycle.

## Timing
- Latency: 2 cycles. A state accepted at edge k is presented on out_state with out_valid=1 after edge k+1.
- Throughput: 1 state per cycle when out_ready is held at 1.
- Capacity: 2 states. With out_ready=0, in_ready falls after two accepts.
- Output stability: while out_valid=1 and out_ready=0, out_state and out_round must not change.
- Reset values: out_valid 0, out_state 0, out_round 0, in_ready 1.

## Test plan
- All-zero state, round 0, out_ready=1 → after 2 cycles, out_state = 0 and out_round = 0.
- All-ones state, round 7 → out_state all ones (every column parity is 1, so D = 0) and out_round = 7.
- Single bit 0 set (x=0, y=0, z=0), round 23 → out_state has exactly 11 bits set: 0, 64, 384, 704, 1024, 1344, 257, 577, 897, 1217, 1537; out_round = 23. Compare against a software theta model on random states as well.
- Back-pressure:
  - Hold out_ready=0 and offer 3 states A, B, C back-to-back: A and B are accepted, then in_ready=0 and C is held by upstream.
  - out_state stays equal to theta(A) throughout.
  - Release out_ready → theta(A), theta(B), theta(C) emerge on consecutive cycles, each with its tag.
- Streaming: 100 random states with out_ready randomly toggled → outputs match the model in order, with no drops or duplicates. Full throughput when out_ready=1.
- Reset mid-operation: pull rst_n low with both stages full → out_valid drops to 0 immediately (asynchronously) and in_ready = 1. After release, a new state emerges correctly 2 cycles after it is accepted, with no stale output.
